// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the decode and execute stages.
//   - ALU op codes for the multiply/divide unit and the HI/LO moves.
//   - muldiv_state_t: states of the iterative multiply/divide sequencer.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] MULT_OP = 6'b000010;
    localparam logic [5:0] DIV_OP  = 6'b000011;
    localparam logic [5:0] MFHI_OP = 6'b000100;
    localparam logic [5:0] MFLO_OP = 6'b000101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single-iteration datapath for the multiply/divide sequencer.
//   MUL: shift-add step on a 2W+1 bit accumulator {carry, upper, multiplier}.
//   DIV: restoring-divide step on {rem, quo}.
// Ports:
//   sel_div   in   1       : 1 = divide step, 0 = multiply step
//   acc       in   2W+1    : product accumulator
//   rem       in   W+1     : partial remainder
//   quo       in   W       : dividend / quotient shift register
//   operand   in   W       : multiplicand (MUL) or divisor (DIV)
//   acc_next  out  2W+1    : accumulator after this step
//   rem_next  out  W+1     : remainder after this step
//   quo_next  out  W       : quotient after this step
// The registers not used by the selected operation pass through unchanged.
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               sel_div,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_next,
    output logic [WIDTH:0]     rem_next,
    output logic [WIDTH-1:0]   quo_next
);

    // Multiply: conditional add into the upper half, carry lands in the
    // extra bit, then the whole accumulator shifts right by one.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_acc;

    assign mul_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    assign mul_acc = {1'b0, mul_sum, acc[WIDTH-1:1]};

    // Divide: shift {rem, quo} left one place, trial-subtract the divisor.
    // The remainder is always below the divisor between steps, so the low
    // W+1 bits of the difference are exact whenever the subtract is taken.
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {2'b00, operand});
    assign div_diff  = div_shift[WIDTH:0] - {1'b0, operand};

    always_comb begin
        acc_next = acc;
        rem_next = rem;
        quo_next = quo;
        if (sel_div) begin
            rem_next = div_ge ? div_diff : div_shift[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], div_ge};
        end else begin
            acc_next = mul_acc;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/DIV controller owning the HI/LO pair for the execute stage.
// An accepted op runs STEPS iterations of muldiv_step, then one FIX cycle
// that applies sign correction and writes HI/LO (33 cycles, fixed latency).
// Build option: MULDIV_SIGNED_EN -- when defined, sgn selects signed
// operation (magnitude capture plus sign correction in FIX); otherwise all
// operations are unsigned and sgn is ignored.
// Ports:
//   clock    in   1  : clock, rising edge
//   reset_n  in   1  : synchronous active-low reset
//   start    in   1  : op on aluop is valid this cycle
//   aluop    in   6  : MULT/DIV/MFHI/MFLO op code, others ignored
//   sgn      in   1  : signed operation
//   rs_val   in   W  : multiplicand / dividend
//   rt_val   in   W  : multiplier / divisor
//   flush    in   1  : abort the in-flight operation
//   busy     out  1  : an operation is in progress
//   stall    out  1  : hold decode/fetch (combinational)
//   result   out  W  : HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo   out  W  : architectural HI/LO
//   divz     out  1  : one-cycle pulse after a divide by zero completes
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       aluop,
    input  logic             sgn,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divz
);

    localparam int            CW         = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(STEPS - 1);

    muldiv_state_t      state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic               div_reg;
    logic [WIDTH-1:0]   operand_reg;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_rs_reg;    // unmodified rs, HI on divide by zero
    logic [2*WIDTH:0]   acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               divz_reg;

    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;

    logic               is_muldiv, is_mf, accept;

    assign is_muldiv = (aluop == MULT_OP) || (aluop == DIV_OP);
    assign is_mf     = (aluop == MFHI_OP) || (aluop == MFLO_OP);
    assign accept    = (state_reg == IDLE) && start && !flush && is_muldiv;

    // ---------------------------------------------------------------------
    // Operand capture and result sign correction
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic               sign_a, sign_b;
    logic               neg_q_reg, neg_r_reg;
    logic [WIDTH:0]     rem_neg;
    logic               unused_rem_msb;

    assign sign_a = sgn & rs_val[WIDTH-1];
    assign sign_b = sgn & rt_val[WIDTH-1];
    // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    assign mag_a  = sign_a ? -rs_val : rs_val;
    assign mag_b  = sign_b ? -rt_val : rt_val;

    // Product and quotient take sa^sb, remainder takes the dividend's sign.
    assign rem_neg        = -rem_reg;
    assign prod_fix       = neg_q_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
    assign quo_fix        = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_fix        = neg_r_reg ? rem_neg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    assign unused_rem_msb = rem_neg[WIDTH];
`else
    logic               unused_sgn;

    assign mag_a      = rs_val;
    assign mag_b      = rt_val;
    assign prod_fix   = acc_reg[2*WIDTH-1:0];
    assign quo_fix    = quo_reg;
    assign rem_fix    = rem_reg[WIDTH-1:0];
    assign unused_sgn = sgn;
`endif

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .sel_div  (div_reg),
        .acc      (acc_reg),
        .rem      (rem_reg),
        .quo      (quo_reg),
        .operand  (operand_reg),
        .acc_next (acc_step),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = ITER;
            ITER: begin
                if (flush)
                    state_next = IDLE;
                else if (count_reg == '0)
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, datapath registers and HI/LO
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            div_reg     <= 1'b0;
            operand_reg <= '0;
            raw_rs_reg  <= '0;
            acc_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            divz_reg    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            divz_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        div_reg    <= (aluop == DIV_OP);
                        count_reg  <= COUNT_LOAD;
                        raw_rs_reg <= rs_val;
`ifdef MULDIV_SIGNED_EN
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
`endif
                        if (aluop == DIV_OP) begin
                            operand_reg <= mag_b;
                            quo_reg     <= mag_a;
                            rem_reg     <= '0;
                            acc_reg     <= '0;
                        end else begin
                            operand_reg <= mag_a;
                            acc_reg     <= {{(WIDTH+1){1'b0}}, mag_b};
                            rem_reg     <= '0;
                            quo_reg     <= '0;
                        end
                    end
                end
                ITER: begin
                    if (!flush) begin
                        acc_reg <= acc_step;
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        if (count_reg != '0)
                            count_reg <= count_reg - CW'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (!div_reg) begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end else if (operand_reg == '0) begin
                            // divisor magnitude is zero exactly when rt was zero
                            hi_reg   <= raw_rs_reg;
                            lo_reg   <= '1;
                            divz_reg <= 1'b1;
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy   = (state_reg != IDLE);
    assign stall  = start & busy & (is_muldiv | is_mf);
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign divz   = divz_reg;
    assign result = (aluop == MFHI_OP) ? hi_reg :
                    (aluop == MFLO_OP) ? lo_reg : '0;

endmodule
